tbps_crc_arb: RTL and testbench
===============================

Name: tbps_crc_arb

Overview:
- Packet-granular round-robin arbiter that shares one tbps_crc_axis engine among N_SRC AXIS input streams.
- Grants one source per packet and muxes its beats into the engine.
- Records the source ID of each packet in an in-order tag FIFO, then labels each engine CRC result with that ID on an AXIS-style output.
- Sits between per-port packet streams and the CRC results consumer.

Parameters:
- N_SRC, 4, number of requesting sources (2..16)
- DWIDTH, 512, data width in bits, multiple of 8
- PIPE_LVL, 0, passed to engine
- CRC_WIDTH, 16, CRC width
- CRC_POLY, 16'h1021, passed to engine
- TAG_DEPTH, 8, tag FIFO depth; power of 2; must be >= packets in flight inside the engine

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- crc_init_val  in  CRC_WIDTH  engine initial value, static
- xor_out  in  CRC_WIDTH  engine output XOR, static
- ref_in  in  1  engine input reflect, static
- ref_out  in  1  engine output reflect, static
- i_data_axis_tdata  in  N_SRC*DWIDTH  source s at slice s
- i_data_axis_tkeep  in  N_SRC*DWIDTH/8  byte enables per source
- i_data_axis_tlast  in  N_SRC  last beat per source
- i_data_axis_tvalid  in  N_SRC  valid per source
- o_data_axis_tready  out  N_SRC  ready per source
- o_crc_axis_tdata  out  CRC_WIDTH  CRC result
- o_crc_axis_tid  out  SRC_W=max(1,clog2(N_SRC))  source of result
- o_crc_axis_tvalid  out  1  result strobe; no backpressure
- o_tag_err  out  1  sticky: engine result with empty tag FIFO, or push while full

Behaviour:
- Reset: clk and rst only; rst is asynchronous, active-high. All state clears: state=IDLE, grant=0, rr_ptr=0, tag FIFO empty, o_data_axis_tready=0, o_crc_axis_tvalid=0, o_crc_axis_tdata=0, o_crc_axis_tid=0, o_tag_err=0. Engine rst is tied to rst.
- States:
  - IDLE: no grant held.
  - BUSY: grant register owns the engine.
- Arbitration (combinational, registered into grant):
  - Candidate = first s with tvalid[s]=1, searching cyclically from rst_ptr.
  - Allowed only if free = TAG_DEPTH - count - push + pop > 0, all evaluated this cycle.
- IDLE -> BUSY(grant=candidate) when a candidate exists and free>0. IDLE never asserts tready.
- BUSY:
  - o_data_axis_tready[grant]=1; all others 0.
  - Engine inputs: din/byteEn/dlast from slice grant; flitEn = tvalid[grant].
  - Accepted beat = tvalid[grant] & tready.
- Accepted beat with tlast=1:
  - Push grant into tag FIFO.
  - rr_ptr <= grant+1, wrapping modulo N_SRC.
  - Same cycle, re-arbitrate with rr_ptr already advanced. If a candidate exists and free>0, go to BUSY with the new grant and no bubble. Otherwise go to IDLE.
- Grant is never revoked mid-packet. A tvalid gap on the granted source holds BUSY.
- Pop on engine crc_out_vld:
  - Same cycle: o_crc_axis_tvalid=1, tdata=crc_out, tid=FIFO head.
  - Outputs are combinational from engine output and FIFO head.
- If pop occurs with the FIFO empty: o_tag_err=1 (sticky), tid=0.
- Simultaneous push and pop: count unchanged. Allowed when full.
- Full FIFO blocks new grants only; an in-progress packet completes. Arbitration checks free>0, so push-when-full cannot occur in legal operation; it still sets o_tag_err.
- Latency: result follows last beat by engine latency. Tag adds 0 cycles.
- Reset mid-packet: grant dropped; engine and FIFO flushed; no result emitted for the partial packet.

Decomposition:
- Package tbps_crc_arb_pkg:
  - arb_state_e {IDLE, BUSY}
  - function src_w(n) returning max(1,clog2(n))
- Sub-module crc_tag_fifo:
  - Synchronous FIFO, width SRC_W, depth TAG_DEPTH.
  - Ports: push, pop, din, dout, count, full, empty, err.
  - Async reset.
- Engine instantiated as tbps_crc_axis.

Test Plan:
- Single packet "123456789" (9 bytes, one beat, DWIDTH=512, tkeep=0x1FF) on src 2, init FFFF, xor 0, no reflection -> one result tdata=0x29B1, tid=2.
- Srcs 0,1,3 each present a 3-beat packet in the same cycle, rr_ptr=0 -> grants 0,1,3 with no bubble; tids 0,1,3 in order; each CRC matches model.
- Only src 1 active, 4 back-to-back 1-beat packets -> continuous tready, 4 results with tid=1, no IDLE cycles.
- TAG_DEPTH=2, PIPE_LVL=4, 1-beat packets from all srcs -> all tready drop once count=2 with no pop; resume after the first result; o_tag_err stays 0.
- Assert rst on beat 2 of a 4-beat src 0 packet, then send a fresh packet from src 3 -> no stale result; first result has tid=3 with correct CRC.
- Force an engine-result pulse with the FIFO empty (bind/force) -> o_tag_err=1 and stays set until rst.

Source files
------------

// File: rtl/tbps_crc_arb_pkg.sv
// Shared types and helpers for the packet round-robin CRC arbiter.
// Imported by the arbiter top and its tag FIFO.
package tbps_crc_arb_pkg;

  typedef enum logic {
    IDLE,
    BUSY
  } arb_state_e;

  function automatic int src_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tbps_crc_arb_fifo.sv
// In-order tag FIFO holding the source ID of each packet inside the engine.
// Pop on empty and push on full (without pop) are ignored and flagged sticky.
module crc_tag_fifo
  import tbps_crc_arb_pkg::*;
#(
  parameter int W     = 2,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          err_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q;
  logic          err_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (do_push) wp_q <= wp_q + AW'(1);
      if (do_pop)  rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      if ((push_i && !do_push) || (pop_i && empty_o)) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wp_q] <= din_i;
  end

  assign dout_o  = empty_o ? '0 : mem_q[rp_q];
  assign count_o = cnt_q;
  assign err_o   = err_q;

endmodule

// File: rtl/tbps_crc_axis.sv
// Byte-serial CRC engine over AXIS-style beats; result is registered and
// delayed by PIPE_LVL extra stages.
module tbps_crc_axis #(
  parameter int                   DWIDTH    = 512,
  parameter int                   PIPE_LVL  = 0,
  parameter int                   CRC_WIDTH = 16,
  parameter logic [CRC_WIDTH-1:0] CRC_POLY  = 16'h1021
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CRC_WIDTH-1:0]   crc_init_val,
  input  logic [CRC_WIDTH-1:0]   xor_out,
  input  logic                   ref_in,
  input  logic                   ref_out,
  input  logic [DWIDTH-1:0]      din,
  input  logic [DWIDTH/8-1:0]    byteEn,
  input  logic                   dlast,
  input  logic                   flitEn,
  output logic [CRC_WIDTH-1:0]   crc_out,
  output logic                   crc_out_vld
);

  localparam int NB = DWIDTH / 8;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = b[7-k];
    return r;
  endfunction

  function automatic logic [CRC_WIDTH-1:0] revc(input logic [CRC_WIDTH-1:0] c);
    logic [CRC_WIDTH-1:0] r;
    for (int k = 0; k < CRC_WIDTH; k++) r[k] = c[CRC_WIDTH-1-k];
    return r;
  endfunction

  logic [CRC_WIDTH-1:0] acc_q, acc_d, crc_c, res_d;
  logic                 mid_q, mid_d, vld_d;
  logic [7:0]           byte_c;
  logic                 fb_c;
  logic [PIPE_LVL:0]    vld_q;
  logic [CRC_WIDTH-1:0] res_q [PIPE_LVL+1];

  // Byte 0 (lowest lane) is shifted in first, MSB of each byte first.
  always_comb begin
    crc_c  = mid_q ? acc_q : crc_init_val;
    byte_c = '0;
    fb_c   = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (byteEn[i]) begin
        byte_c = ref_in ? rev8(din[8*i +: 8]) : din[8*i +: 8];
        for (int j = 7; j >= 0; j--) begin
          fb_c  = crc_c[CRC_WIDTH-1] ^ byte_c[j];
          crc_c = {crc_c[CRC_WIDTH-2:0], 1'b0} ^ (fb_c ? CRC_POLY : '0);
        end
      end
    end
  end

  always_comb begin
    acc_d = acc_q;
    mid_d = mid_q;
    vld_d = 1'b0;
    res_d = '0;
    if (flitEn) begin
      if (dlast) begin
        mid_d = 1'b0;
        vld_d = 1'b1;
        res_d = (ref_out ? revc(crc_c) : crc_c) ^ xor_out;
      end else begin
        mid_d = 1'b1;
        acc_d = crc_c;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      mid_q <= 1'b0;
      vld_q <= '0;
      for (int k = 0; k <= PIPE_LVL; k++) res_q[k] <= '0;
    end else begin
      acc_q    <= acc_d;
      mid_q    <= mid_d;
      vld_q[0] <= vld_d;
      res_q[0] <= res_d;
      for (int k = 1; k <= PIPE_LVL; k++) begin
        vld_q[k] <= vld_q[k-1];
        res_q[k] <= res_q[k-1];
      end
    end
  end

  assign crc_out     = res_q[PIPE_LVL];
  assign crc_out_vld = vld_q[PIPE_LVL];

endmodule

// File: rtl/tbps_crc_arb.sv
// Packet-granular round-robin arbiter sharing one CRC engine between
// N_SRC AXIS sources; results are tagged with the originating source.
module tbps_crc_arb
  import tbps_crc_arb_pkg::*;
#(
  parameter int                   N_SRC     = 4,
  parameter int                   DWIDTH    = 512,
  parameter int                   PIPE_LVL  = 0,
  parameter int                   CRC_WIDTH = 16,
  parameter logic [CRC_WIDTH-1:0] CRC_POLY  = 16'h1021,
  parameter int                   TAG_DEPTH = 8,
  localparam int                  SRC_W     = src_w(N_SRC),
  localparam int                  CW        = $clog2(TAG_DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CRC_WIDTH-1:0]       crc_init_val,
  input  logic [CRC_WIDTH-1:0]       xor_out,
  input  logic                       ref_in,
  input  logic                       ref_out,
  input  logic [N_SRC*DWIDTH-1:0]    i_data_axis_tdata,
  input  logic [N_SRC*DWIDTH/8-1:0]  i_data_axis_tkeep,
  input  logic [N_SRC-1:0]           i_data_axis_tlast,
  input  logic [N_SRC-1:0]           i_data_axis_tvalid,
  output logic [N_SRC-1:0]           o_data_axis_tready,
  output logic [CRC_WIDTH-1:0]       o_crc_axis_tdata,
  output logic [SRC_W-1:0]           o_crc_axis_tid,
  output logic                       o_crc_axis_tvalid,
  output logic                       o_tag_err
);

  localparam int BW = DWIDTH / 8;

  arb_state_e     state_q, state_d;
  logic [SRC_W-1:0] grant_q, grant_d, rr_q, rr_d;
  logic [SRC_W-1:0] nxt_c, cand_c, tag_dout;
  logic           acc_c, push_c, cand_vld, busy_c;
  logic           eng_vld, tag_full, tag_empty;
  logic [CRC_WIDTH-1:0] eng_crc;
  logic [CW-1:0]  tag_cnt;
  int             base_c, free_c;

  assign busy_c = (state_q == BUSY);

  always_comb begin
    acc_c  = busy_c && i_data_axis_tvalid[grant_q];
    push_c = acc_c && i_data_axis_tlast[grant_q];
    nxt_c  = (int'(grant_q) == N_SRC-1) ? '0 : grant_q + SRC_W'(1);
    // A finishing packet re-arbitrates from the already advanced pointer.
    base_c = push_c ? int'(nxt_c) : int'(rr_q);
    free_c = (tag_full && !eng_vld) ? 0 :
             TAG_DEPTH - int'(tag_cnt) - int'(push_c) + int'(eng_vld);
    cand_vld = 1'b0;
    cand_c   = '0;
    for (int k = N_SRC-1; k >= 0; k--) begin
      if (i_data_axis_tvalid[(base_c + k) % N_SRC]) begin
        cand_vld = 1'b1;
        cand_c   = SRC_W'((base_c + k) % N_SRC);
      end
    end
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    unique case (state_q)
      IDLE: begin
        if (cand_vld && free_c > 0) begin
          state_d = BUSY;
          grant_d = cand_c;
        end
      end
      BUSY: begin
        if (push_c) begin
          rr_d = nxt_c;
          if (cand_vld && free_c > 0) begin
            grant_d = cand_c;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  assign o_data_axis_tready = busy_c ? (N_SRC'(1) << grant_q) : '0;

  tbps_crc_axis #(
    .DWIDTH    (DWIDTH),
    .PIPE_LVL  (PIPE_LVL),
    .CRC_WIDTH (CRC_WIDTH),
    .CRC_POLY  (CRC_POLY)
  ) u_eng (
    .clk          (clk),
    .rst          (rst),
    .crc_init_val (crc_init_val),
    .xor_out      (xor_out),
    .ref_in       (ref_in),
    .ref_out      (ref_out),
    .din          (i_data_axis_tdata[grant_q*DWIDTH +: DWIDTH]),
    .byteEn       (i_data_axis_tkeep[grant_q*BW +: BW]),
    .dlast        (i_data_axis_tlast[grant_q]),
    .flitEn       (acc_c),
    .crc_out      (eng_crc),
    .crc_out_vld  (eng_vld)
  );

  crc_tag_fifo #(
    .W     (SRC_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push_c),
    .pop_i   (eng_vld),
    .din_i   (grant_q),
    .dout_o  (tag_dout),
    .count_o (tag_cnt),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .err_o   (o_tag_err)
  );

  assign o_crc_axis_tvalid = eng_vld;
  assign o_crc_axis_tdata  = eng_crc;
  assign o_crc_axis_tid    = tag_empty ? '0 : tag_dout;

endmodule

// File: tb/tb_tbps_crc_arb.sv
// Scoreboard bench for tbps_crc_arb: drivers push expected tagged CRCs,
// per-instance monitors pop and compare on every result strobe.
module tb_tbps_crc_arb;

  localparam int NS = 4;
  localparam int DW = 512;
  localparam int NB = DW / 8;

  typedef struct packed {
    logic [15:0] crc;
    logic [1:0]  tid;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] dd [2][NS];
  logic [NB-1:0] kk [2][NS];
  logic          ll [2][NS];
  logic          vv [2][NS];

  logic [NS*DW-1:0] td [2];
  logic [NS*NB-1:0] tk [2];
  logic [NS-1:0]    tl [2];
  logic [NS-1:0]    tv [2];
  logic [NS-1:0]    trd [2];
  logic [15:0]      rdat [2];
  logic [1:0]       rtid [2];
  logic             rvld [2];
  logic             rerr [2];

  for (genvar d = 0; d < 2; d++) begin : g_d
    for (genvar s = 0; s < NS; s++) begin : g_s
      assign td[d][s*DW +: DW] = dd[d][s];
      assign tk[d][s*NB +: NB] = kk[d][s];
      assign tl[d][s] = ll[d][s];
      assign tv[d][s] = vv[d][s];
    end
  end

  tbps_crc_arb #(
    .N_SRC(NS), .DWIDTH(DW), .PIPE_LVL(0), .CRC_WIDTH(16),
    .CRC_POLY(16'h1021), .TAG_DEPTH(8)
  ) dut0 (
    .clk(clk), .rst(rst), .crc_init_val(16'hFFFF), .xor_out(16'h0000),
    .ref_in(1'b0), .ref_out(1'b0),
    .i_data_axis_tdata(td[0]), .i_data_axis_tkeep(tk[0]),
    .i_data_axis_tlast(tl[0]), .i_data_axis_tvalid(tv[0]),
    .o_data_axis_tready(trd[0]), .o_crc_axis_tdata(rdat[0]),
    .o_crc_axis_tid(rtid[0]), .o_crc_axis_tvalid(rvld[0]),
    .o_tag_err(rerr[0])
  );

  tbps_crc_arb #(
    .N_SRC(NS), .DWIDTH(DW), .PIPE_LVL(4), .CRC_WIDTH(16),
    .CRC_POLY(16'h1021), .TAG_DEPTH(2)
  ) dut1 (
    .clk(clk), .rst(rst), .crc_init_val(16'hFFFF), .xor_out(16'h0000),
    .ref_in(1'b0), .ref_out(1'b0),
    .i_data_axis_tdata(td[1]), .i_data_axis_tkeep(tk[1]),
    .i_data_axis_tlast(tl[1]), .i_data_axis_tvalid(tv[1]),
    .o_data_axis_tready(trd[1]), .o_crc_axis_tdata(rdat[1]),
    .o_crc_axis_tid(rtid[1]), .o_crc_axis_tvalid(rvld[1]),
    .o_tag_err(rerr[1])
  );

  exp_t q0[$];
  exp_t q1[$];
  bit   spur = 1'b0;
  int   acc_n, acc_first, acc_last;
  int   acc1[$];
  int   res1_n, res1_first;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input logic [7:0] seed,
                                              input int b, input int n);
    logic [DW-1:0] r;
    for (int k = 0; k < NB; k++)
      r[8*k +: 8] = (k < n) ? 8'(int'(seed) + b*NB + k) : 8'hA5;
    return r;
  endfunction

  function automatic logic [NB-1:0] keep_of(input int n);
    logic [NB-1:0] r;
    for (int k = 0; k < NB; k++) r[k] = (k < n);
    return r;
  endfunction

  // CRC-16/CCITT-FALSE, classic byte-wise MSB-first formulation.
  function automatic logic [15:0] model_crc(input logic [7:0] seed,
                                            input int nb, input int nl);
    logic [15:0] c;
    logic [7:0]  x;
    c = 16'hFFFF;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < ((b == nb-1) ? nl : NB); k++) begin
        x = 8'(int'(seed) + b*NB + k);
        c = c ^ {x, 8'h00};
        for (int i = 0; i < 8; i++)
          c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
      end
    end
    return c;
  endfunction

  // Must be entered at a negedge; returns at a negedge.
  task automatic send_pkt(input int d, input int s, input int nb,
                          input int nl, input logic [7:0] seed,
                          input bit fx, input logic [15:0] fcrc);
    exp_t e;
    int   g;
    e.crc = fx ? fcrc : model_crc(seed, nb, nl);
    e.tid = 2'(s);
    for (int b = 0; b < nb; b++) begin
      dd[d][s] = beat_data(seed, b, (b == nb-1) ? nl : NB);
      kk[d][s] = keep_of((b == nb-1) ? nl : NB);
      ll[d][s] = (b == nb-1);
      vv[d][s] = 1'b1;
      g = 0;
      while (!trd[d][s] && g < 3000) begin
        @(negedge clk);
        g++;
      end
      if (g >= 3000) begin
        chk($sformatf("tready_wait_d%0d_s%0d", d, s), 32'(g), 32'd0);
        vv[d][s] = 1'b0;
        return;
      end
      if (b == nb-1) begin
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
      end
      @(negedge clk);
    end
    vv[d][s] = 1'b0;
    ll[d][s] = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((q0.size() != 0 || q1.size() != 0) && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk("drain", 32'(q0.size() + q1.size()), 32'd0);
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < NS; s++) begin
        vv[d][s] = 1'b0;
        ll[d][s] = 1'b0;
      end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && |(tv[0] & trd[0])) begin
      if (acc_n == 0) acc_first = cyc;
      acc_last = cyc;
      acc_n++;
    end
    if (!rst && |(tv[1] & trd[1])) acc1.push_back(cyc);
    if (!rst && rvld[0]) begin
      if (spur) chk("spur_tid", 32'(rtid[0]), 32'd0);
      else if (q0.size() == 0) chk("unexpected_result0", 32'(rdat[0]), 32'hDEAD_0000);
      else begin
        e = q0.pop_front();
        chk("crc0", 32'(rdat[0]), 32'(e.crc));
        chk("tid0", 32'(rtid[0]), 32'(e.tid));
      end
    end
    if (!rst && rvld[1]) begin
      if (res1_n == 0) res1_first = cyc;
      res1_n++;
      if (q1.size() == 0) chk("unexpected_result1", 32'(rdat[1]), 32'hDEAD_0000);
      else begin
        e = q1.pop_front();
        chk("crc1", 32'(rdat[1]), 32'(e.crc));
        chk("tid1", 32'(rtid[1]), 32'(e.tid));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    acc_n = 0; acc_first = 0; acc_last = 0; res1_n = 0; res1_first = 0;
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < NS; s++) begin
        dd[d][s] = '0; kk[d][s] = '0; ll[d][s] = 1'b0; vv[d][s] = 1'b0;
      end
    repeat (3) @(negedge clk);
    chk("rst_tready", 32'(trd[0]), 32'd0);
    chk("rst_tvalid", 32'(rvld[0]), 32'd0);
    chk("rst_tdata", 32'(rdat[0]), 32'd0);
    chk("rst_tid", 32'(rtid[0]), 32'd0);
    chk("rst_err", 32'(rerr[0]), 32'd0);
    chk("rst_tready1", 32'(trd[1]), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // "123456789" on src 2 -> CRC-16/CCITT-FALSE 0x29B1
    send_pkt(0, 2, 1, 9, 8'h31, 1'b1, 16'h29B1);
    drain();
    do_reset();

    // Three concurrent 3-beat packets, rr starts at 0
    acc_n = 0;
    fork
      send_pkt(0, 0, 3, 64, 8'h40, 1'b0, 16'h0);
      send_pkt(0, 1, 3, 37, 8'h81, 1'b0, 16'h0);
      send_pkt(0, 3, 3, 5, 8'hC3, 1'b0, 16'h0);
    join
    drain();
    chk("t2_beats", 32'(acc_n), 32'd9);
    chk("t2_nobubble", 32'(acc_last - acc_first + 1), 32'd9);
    do_reset();

    // Back-to-back single-beat packets from src 1
    acc_n = 0;
    for (int i = 0; i < 4; i++)
      send_pkt(0, 1, 1, 8 + i*10, 8'(8'h11 + i), 1'b0, 16'h0);
    drain();
    chk("t3_beats", 32'(acc_n), 32'd4);
    chk("t3_nobubble", 32'(acc_last - acc_first + 1), 32'd4);
    do_reset();

    // TAG_DEPTH=2, PIPE_LVL=4: third grant waits for first result
    acc1.delete();
    res1_n = 0;
    fork
      send_pkt(1, 0, 1, 16, 8'h20, 1'b0, 16'h0);
      send_pkt(1, 1, 1, 16, 8'h21, 1'b0, 16'h0);
      send_pkt(1, 2, 1, 16, 8'h22, 1'b0, 16'h0);
      send_pkt(1, 3, 1, 16, 8'h23, 1'b0, 16'h0);
    join
    drain();
    chk("t4_beats", 32'(acc1.size()), 32'd4);
    chk("t4_results", 32'(res1_n), 32'd4);
    if (acc1.size() == 4) begin
      chk("t4_first_two_adjacent", 32'(acc1[1] - acc1[0]), 32'd1);
      chk("t4_stall_until_result", 32'(acc1[2] > res1_first), 32'd1);
      chk("t4_stall_gap", 32'(acc1[2] - acc1[1] > 1), 32'd1);
    end
    chk("t4_tag_err", 32'(rerr[1]), 32'd0);
    do_reset();

    // Reset in the middle of a 4-beat src 0 packet
    dd[0][0] = beat_data(8'h10, 0, NB);
    kk[0][0] = keep_of(NB);
    ll[0][0] = 1'b0;
    vv[0][0] = 1'b1;
    g = 0;
    while (!trd[0][0] && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("t5_grant", 32'(trd[0][0]), 32'd1);
    @(negedge clk);
    dd[0][0] = beat_data(8'h10, 1, NB);
    @(negedge clk);
    dd[0][0] = beat_data(8'h10, 2, NB);
    rst = 1'b1;
    vv[0][0] = 1'b0;
    #1;
    chk("t5_rst_tready", 32'(trd[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    send_pkt(0, 3, 2, 20, 8'h77, 1'b0, 16'h0);
    drain();

    // Engine strobe with empty tag FIFO
    chk("t6_err_pre", 32'(rerr[0]), 32'd0);
    @(posedge clk);
    #1;
    spur = 1'b1;
    force dut0.eng_vld = 1'b1;
    @(posedge clk);
    #1;
    release dut0.eng_vld;
    spur = 1'b0;
    chk("t6_err_set", 32'(rerr[0]), 32'd1);
    repeat (5) @(negedge clk);
    chk("t6_err_sticky", 32'(rerr[0]), 32'd1);
    do_reset();
    chk("t6_err_clr", 32'(rerr[0]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
